// File: rtl/ds1302_pkg.sv
// Shared constants, state encoding and character helpers for the DS1302 time-line formatter.
// The frame layout is "20YY-MM-DD W HH:MM:SS" + CR + LF (23 bytes).
package ds1302_pkg;

    localparam int         FRAME_LEN = 23;
    localparam logic [4:0] LAST_IDX  = 5'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_TWO   = 8'h32;

    // Fields are stored already masked (CH bit, 12/24 bits, week high nibble stripped).
    typedef struct packed {
        logic [7:0] yea;
        logic [7:0] mon;
        logic [7:0] day;
        logic [7:0] wek;
        logic [7:0] hou;
        logic [7:0] min;
        logic [7:0] sec;
    } snapshot_t;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nibble);
        return (nibble > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'd0, nibble});
    endfunction

    function automatic logic [7:0] frame_char(input logic [4:0] idx, input snapshot_t snap);
        logic [7:0] ch;
        case (idx)
            5'd0:    ch = ASCII_TWO;
            5'd1:    ch = ASCII_ZERO;
            5'd2:    ch = bcd_to_ascii(snap.yea[7:4]);
            5'd3:    ch = bcd_to_ascii(snap.yea[3:0]);
            5'd4:    ch = ASCII_DASH;
            5'd5:    ch = bcd_to_ascii(snap.mon[7:4]);
            5'd6:    ch = bcd_to_ascii(snap.mon[3:0]);
            5'd7:    ch = ASCII_DASH;
            5'd8:    ch = bcd_to_ascii(snap.day[7:4]);
            5'd9:    ch = bcd_to_ascii(snap.day[3:0]);
            5'd10:   ch = ASCII_SPACE;
            5'd11:   ch = bcd_to_ascii(snap.wek[3:0]);
            5'd12:   ch = ASCII_SPACE;
            5'd13:   ch = bcd_to_ascii(snap.hou[7:4]);
            5'd14:   ch = bcd_to_ascii(snap.hou[3:0]);
            5'd15:   ch = ASCII_COLON;
            5'd16:   ch = bcd_to_ascii(snap.min[7:4]);
            5'd17:   ch = bcd_to_ascii(snap.min[3:0]);
            5'd18:   ch = ASCII_COLON;
            5'd19:   ch = bcd_to_ascii(snap.sec[7:4]);
            5'd20:   ch = bcd_to_ascii(snap.sec[3:0]);
            5'd21:   ch = ASCII_CR;
            5'd22:   ch = ASCII_LF;
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/ds1302_uart_fmt.sv
// Snapshots the DS1302 BCD time registers on a seconds change or request and streams
// the formatted ASCII line byte by byte into a UART transmitter via a pulse/busy handshake.
module ds1302_uart_fmt
    import ds1302_pkg::*;
#(
    parameter int CLK_FRE     = 50,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sec_data,
    input  logic [7:0]  min_data,
    input  logic [7:0]  hou_data,
    input  logic [7:0]  day_data,
    input  logic [7:0]  mon_data,
    input  logic [7:0]  wek_data,
    input  logic [7:0]  yea_data,
    input  logic        print_req,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_busy,
    output logic        frame_busy,
    output logic [15:0] frame_cnt,
    output logic        timeout_err
);

    localparam int               ACK_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    if (CLK_FRE < 1 || ACK_TIMEOUT < 1) begin : g_bad_param
        $error("ds1302_uart_fmt: CLK_FRE and ACK_TIMEOUT must be positive");
    end

    state_t           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    snapshot_t        snap_q, snap_d;
    logic [6:0]       last_sec_q, last_sec_d;
    logic             pending_q, pending_d;
    logic             start_q, start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_en_q, tx_en_d;
    logic             frame_busy_q, frame_busy_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;

    logic trigger;
    logic byte_done;

    assign trigger = (sec_data[6:0] != last_sec_q) || print_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= 5'd0;
            snap_q        <= '0;
            last_sec_q    <= 7'h7F;
            pending_q     <= 1'b0;
            start_q       <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_en_q       <= 1'b0;
            frame_busy_q  <= 1'b0;
            frame_cnt_q   <= 16'd0;
            timeout_err_q <= 1'b0;
            ack_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            last_sec_q    <= last_sec_d;
            pending_q     <= pending_d;
            start_q       <= start_d;
            tx_data_q     <= tx_data_d;
            tx_en_q       <= tx_en_d;
            frame_busy_q  <= frame_busy_d;
            frame_cnt_q   <= frame_cnt_d;
            timeout_err_q <= timeout_err_d;
            ack_cnt_q     <= ack_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        snap_d        = snap_q;
        last_sec_d    = last_sec_q;
        pending_d     = pending_q;
        start_d       = start_q;
        tx_data_d     = tx_data_q;
        tx_en_d       = 1'b0;
        frame_busy_d  = frame_busy_q;
        frame_cnt_d   = frame_cnt_q;
        timeout_err_d = timeout_err_q;
        ack_cnt_d     = ack_cnt_q;
        byte_done     = 1'b0;

        // Any number of triggers during a frame collapse into one follow-up frame.
        if (frame_busy_q && trigger) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Capture edge and SEND entry are one cycle apart, so the snapshot
                // is registered before the first character is selected from it.
                if (start_q) begin
                    start_d = 1'b0;
                    state_d = SEND;
                end else if (trigger || pending_q) begin
                    snap_d.yea   = yea_data;
                    snap_d.mon   = mon_data;
                    snap_d.day   = day_data;
                    snap_d.wek   = {4'h0, wek_data[3:0]};
                    snap_d.hou   = {2'b00, hou_data[5:0]};
                    snap_d.min   = min_data;
                    snap_d.sec   = {1'b0, sec_data[6:0]};
                    last_sec_d   = sec_data[6:0];
                    idx_d        = 5'd0;
                    frame_busy_d = 1'b1;
                    pending_d    = 1'b0;
                    start_d      = 1'b1;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_data_d = frame_char(idx_q, snap_q);
                    tx_en_d   = 1'b1;
                    ack_cnt_d = '0;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    timeout_err_d = 1'b1;
                    byte_done     = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (byte_done) begin
            if (idx_q == LAST_IDX) begin
                frame_cnt_d  = frame_cnt_q + 16'd1;
                frame_busy_d = 1'b0;
                state_d      = IDLE;
            end else begin
                idx_d   = idx_q + 5'd1;
                state_d = SEND;
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_en       = tx_en_q;
    assign frame_busy  = frame_busy_q;
    assign frame_cnt   = frame_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ds1302_uart_fmt.sv
// Directed bench for ds1302_uart_fmt: a UART busy model plus a byte scoreboard fed with
// the expected text line whenever a frame is triggered.
module tb_ds1302_uart_fmt;

    localparam int ACK_TO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sec_data, min_data, hou_data, day_data, mon_data, wek_data, yea_data;
    logic        print_req = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_busy = 1'b0;
    logic        frame_busy;
    logic [15:0] frame_cnt;
    logic        timeout_err;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [7:0]  sb_q[$];
    int          bytes_seen = 0;
    logic        prev_en = 1'b0;
    int          busy_len = 10;
    int          busy_cnt = 0;
    logic [7:0]  exp_byte;
    int          base;

    ds1302_uart_fmt #(.CLK_FRE(50), .ACK_TIMEOUT(ACK_TO)) dut (
        .clk(clk), .rst(rst),
        .sec_data(sec_data), .min_data(min_data), .hou_data(hou_data),
        .day_data(day_data), .mon_data(mon_data), .wek_data(wek_data),
        .yea_data(yea_data), .print_req(print_req),
        .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
        .frame_busy(frame_busy), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] dig(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h3F;
    endfunction

    // Expected line built from the bench's own current register values.
    task automatic push_frame();
        logic [7:0] line [23];
        logic [7:0] hh, ss;
        hh = hou_data & 8'h3F;
        ss = sec_data & 8'h7F;
        line = '{8'h32, 8'h30, dig(yea_data[7:4]), dig(yea_data[3:0]), 8'h2D,
                 dig(mon_data[7:4]), dig(mon_data[3:0]), 8'h2D,
                 dig(day_data[7:4]), dig(day_data[3:0]), 8'h20,
                 dig(wek_data[3:0]), 8'h20,
                 dig(hh[7:4]), dig(hh[3:0]), 8'h3A,
                 dig(min_data[7:4]), dig(min_data[3:0]), 8'h3A,
                 dig(ss[7:4]), dig(ss[3:0]), 8'h0D, 8'h0A};
        foreach (line[i]) sb_q.push_back(line[i]);
    endtask

    // Scoreboard consumer and UART busy model, both sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_en) begin
            check("tx_en_single_cycle", {31'd0, prev_en}, 32'd0);
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $error("FAIL tx_byte: observed %02h expected none (scoreboard empty)", tx_data);
            end else begin
                exp_byte = sb_q.pop_front();
                check($sformatf("tx_byte_%0d", bytes_seen), {24'd0, tx_data}, {24'd0, exp_byte});
            end
            bytes_seen++;
        end
        prev_en = tx_en;
        if (tx_en && busy_len > 0) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy = (busy_cnt > 0);
    end

    task automatic pulse_req();
        print_req = 1'b1;
        @(negedge clk);
        print_req = 1'b0;
    endtask

    task automatic wait_frames_done(input int budget);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((frame_busy || sb_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_done_in_budget", {31'd0, (n < budget)}, 32'd1);
    endtask

    task automatic wait_bytes(input int target, input int budget);
        int n;
        n = 0;
        while (bytes_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("bytes_reached_in_budget", {31'd0, (n < budget)}, 32'd1);
    endtask

    initial begin
        sec_data = 8'h06; min_data = 8'h05; hou_data = 8'h09; day_data = 8'h15;
        mon_data = 8'h01; wek_data = 8'h03; yea_data = 8'h22;
        repeat (3) @(negedge clk);
        check("rst_tx_en", {31'd0, tx_en}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_frame_busy", {31'd0, frame_busy}, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);

        // First valid seconds after reset starts a frame.
        push_frame();
        rst = 1'b0;
        wait_frames_done(2000);
        check("cnt_after_first", {16'd0, frame_cnt}, 32'd1);

        // Seconds 06 -> 07.
        sec_data = 8'h07;
        push_frame();
        wait_frames_done(2000);
        check("cnt_after_sec07", {16'd0, frame_cnt}, 32'd2);
        check("no_timeout_normal", {31'd0, timeout_err}, 32'd0);

        // Clock-halt bit, 12h-mode hour bits and a non-decimal nibble.
        sec_data = 8'h87; hou_data = 8'h52; min_data = 8'h5A;
        push_frame();
        pulse_req();
        wait_frames_done(2000);
        check("cnt_after_masked", {16'd0, frame_cnt}, 32'd3);

        // Triggers mid-frame: current frame unchanged, one follow-up frame.
        sec_data = 8'h07; hou_data = 8'h09; min_data = 8'h05;
        base = bytes_seen;
        push_frame();
        pulse_req();
        wait_bytes(base + 5, 500);
        sec_data = 8'h08;
        push_frame();
        wait_bytes(base + 12, 500);
        pulse_req();
        wait_frames_done(4000);
        check("cnt_after_pending", {16'd0, frame_cnt}, 32'd5);
        check("bytes_after_pending", base + 46, bytes_seen);

        // UART never acknowledges: every byte times out, frame still completes.
        busy_len = 0;
        check("timeout_clear_before", {31'd0, timeout_err}, 32'd0);
        push_frame();
        pulse_req();
        wait_frames_done(3000);
        check("timeout_set", {31'd0, timeout_err}, 32'd1);
        check("cnt_after_timeout", {16'd0, frame_cnt}, 32'd6);
        busy_len = 10;

        // Reset in the middle of a frame.
        base = bytes_seen;
        push_frame();
        pulse_req();
        wait_bytes(base + 10, 500);
        base = bytes_seen;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_en", {31'd0, tx_en}, 32'd0);
        check("midrst_frame_busy", {31'd0, frame_busy}, 32'd0);
        check("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("midrst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("midrst_tx_data", {24'd0, tx_data}, 32'h00);
        sb_q.delete();
        push_frame();
        rst = 1'b0;
        wait_frames_done(2000);
        check("cnt_after_midrst", {16'd0, frame_cnt}, 32'd1);
        check("bytes_after_midrst", base + 23, bytes_seen);

        // print_req and seconds change in the same cycle: one frame, strobe at k+2.
        sec_data = 8'h09;
        print_req = 1'b1;
        push_frame();
        @(negedge clk);
        print_req = 1'b0;
        check("lat_k0_tx_en", {31'd0, tx_en}, 32'd0);
        @(negedge clk);
        check("lat_k1_tx_en", {31'd0, tx_en}, 32'd0);
        @(negedge clk);
        check("lat_k2_tx_en", {31'd0, tx_en}, 32'd1);
        wait_frames_done(2000);
        repeat (20) @(negedge clk);
        check("single_frame_busy", {31'd0, frame_busy}, 32'd0);
        check("single_frame_cnt", {16'd0, frame_cnt}, 32'd2);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ds1302_uart_fmt.md
# ds1302_uart_fmt

Downstream consumer of the DS1302 reader's BCD time registers. On every change of seconds, or on explicit request, it snapshots all seven BCD registers, formats them as a 23-byte ASCII line, and streams the bytes one at a time into the project's UART transmitter. It uses the same pulse/busy handshake that the DS1302 reader uses toward its serial driver.

## Interface
- `CLK_FRE`, default 50: clock frequency in MHz; documentation only, not used in logic.
- `ACK_TIMEOUT`, default 1000: cycles to wait for `tx_busy` to rise after `tx_en`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high; single clock domain.
- `sec_data`, `min_data`, `hou_data`, `day_data`, `mon_data`, `wek_data`, `yea_data`  in  8 each  raw DS1302 BCD registers.
- `print_req`  in  1  single-cycle request to print the current time.
- `tx_data`  out  8  byte offered to the UART transmitter.
- `tx_en`  out  1  single-cycle send strobe.
- `tx_busy`  in  1  UART transmitter busy.
- `frame_busy`  out  1  high while a frame is in progress.
- `frame_cnt`  out  16  count of completed frames; wraps at 16'hFFFF→0.
- `timeout_err`  out  1  sticky; set by any ACK timeout; cleared only by `rst`.

## Operation
- Frame format: `20YY-MM-DD W HH:MM:SS` followed by CR (8'h0D) and LF (8'h0A). Byte index 0..22.
- Field masking:
  - seconds use `sec_data[6:0]` (bit 7 is clock-halt).
  - hours use `hou_data[5:0]`.
  - week prints the low nibble only.
  - all other fields use the full byte.
- Digit encoding: nibble 0-9 → 8'h30+nibble; nibble >9 → '?' (8'h3F).
- Trigger: `sec_data[6:0] != last_sec` or `print_req`. `last_sec` resets to 7'h7F, so the first valid seconds value triggers a frame.
- Snapshot: on trigger, all seven registers are latched. The frame prints only the snapshot; input changes during the frame do not affect it.
- State machine:
  - IDLE → SEND on trigger. Action: capture snapshot, `last_sec`←`sec_data[6:0]`, idx←0, `frame_busy`←1.
  - SEND → WAIT_ACK when `!tx_busy`. Action: drive `tx_data`←char(idx), `tx_en`←1.
  - WAIT_ACK: `tx_en`←0 (exactly one cycle high).
    - `tx_busy`=1 → WAIT_DONE.
    - No `tx_busy` after `ACK_TIMEOUT` cycles → set `timeout_err`, treat the byte as sent, take the WAIT_DONE exit path directly.
  - WAIT_DONE, when `!tx_busy`:
    - idx<22 → idx+1, go to SEND.
    - idx=22 → `frame_cnt`+1, `frame_busy`←0, go to IDLE.
- Pending trigger:
  - A trigger during a frame (seconds change or `print_req`) sets a 1-bit `pending` flag.
  - At frame end with `pending`=1: clear `pending`, go to IDLE. The IDLE check takes a fresh snapshot of the then-current time.
  - Multiple triggers during one frame collapse to a single follow-up frame.
- While `frame_busy`=1, a seconds change does not update `last_sec`.

## Timing
- Reset values: `tx_en`=0, `tx_data`=8'h00, `frame_busy`=0, `frame_cnt`=0, `timeout_err`=0, state=IDLE, idx=0, `pending`=0.
- Trigger sampled at edge k. SEND is entered at k+1. With `tx_busy`=0, `tx_en` is high during the cycle after edge k+2.
- Inter-byte gap: 2 cycles after `tx_busy` falls. With the minimum 1-cycle busy, one byte every ≥5 cycles.
- `rst` mid-frame: at the next edge all outputs return to reset values, `tx_en` drops immediately, and the remaining bytes are discarded.
- `tx_busy` already high in SEND: hold, no strobe, until it falls.
- `print_req` coinciding with a seconds change in IDLE produces one frame, not two.

## Structure
- Package `ds1302_pkg` holds:
  - `FRAME_LEN`=23
  - the state enum {IDLE, SEND, WAIT_ACK, WAIT_DONE}
  - ASCII constants (CR, LF, '-', ':', ' ', '?')
  - function `bcd_to_ascii(nibble)`
  - function `frame_char(idx, snapshot)`
- No sub-module. The character select is a combinational function of idx. The UART transmitter is instantiated by the parent.

## Test plan
- Registers 22/01/15, wek 3, 09:05:07 with sec changing 06→07, UART model busy for 10 cycles per byte → exactly `2022-01-15 3 09:05:07\r\n` (23 bytes), `frame_cnt`=1, one `tx_en` pulse per byte.
- `sec_data`=8'h87 (CH set), `hou_data`=8'h52 → line shows `:07` and `12`; `min_data`=8'h5A → `5?`.
- Seconds change at byte 5 and `print_req` at byte 12 → current frame completes unaltered from its snapshot; exactly one follow-up frame shows the new time; `frame_cnt`=2.
- `tx_busy` stuck low → after `ACK_TIMEOUT` cycles per byte `timeout_err`=1, frame still finishes, `frame_cnt`=1.
- `rst` pulsed at byte 10 → `tx_en`=0 and `frame_busy`=0 next cycle; after release the first valid seconds value starts a full new frame from index 0.
- `print_req` and a seconds change in the same cycle → single frame; `tx_en` first high 2 cycles after the trigger edge.
